// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam int DEF_MEM_WIDTH = 128;
  localparam int LINE_OFF      = $clog2(DEF_MEM_WIDTH / 8);

  function automatic int line_off_of(input int mem_width);
    return $clog2(mem_width / 8);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Main-memory port bus: master = arbiter, slave = memory controller.
interface mem_port_arbiter_if #(
    parameter int MEM_WIDTH  = 128,
    parameter int ADDR_WIDTH = 32
);
    logic                  ce_n;
    logic                  we_n;
    logic                  oe_n;
    logic                  bw;
    logic                  multiple_read;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [MEM_WIDTH-1:0]  rdata;
    logic                  hold;

    modport master (output ce_n, we_n, oe_n, bw, multiple_read, addr, wdata,
                    input  rdata, hold);
    modport slave  (input  ce_n, we_n, oe_n, bw, multiple_read, addr, wdata,
                    output rdata, hold);
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-input grant between I-cache and data port; remembers the last owner served.
// ARB_FIXED_PRIO_EN: data port always wins ties instead of alternating.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   req_i,
    input  logic   req_d,
    input  logic   update,
    input  owner_t done_owner,
    output owner_t grant
);
    owner_t last_grant;

    always_ff @(posedge clk) begin
        if (reset)       last_grant <= OWN_D;
        else if (update) last_grant <= done_owner;
    end

`ifdef ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = (last_grant == OWN_I);

    always_comb begin
        grant = OWN_D;
        if (req_i && !req_d) grant = OWN_I;
    end
`else
    always_comb begin
        grant = OWN_D;
        if (req_i && req_d) grant = (last_grant == OWN_D) ? OWN_I : OWN_D;
        else if (req_i)     grant = OWN_I;
    end
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory port between I-cache refill and the CPU data port.
// ARB_FIXED_PRIO_EN selects fixed data-first priority instead of round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 0,
    parameter int MEM_WIDTH   = 128,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_req,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic [MEM_WIDTH-1:0]  ic_rdata,
    output logic                  ic_done,
    input  logic                  d_ce,
    input  logic                  d_rw,
    input  logic                  d_bw,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic [31:0]           d_rdata,
    output logic                  d_done,
    output logic                  d_hold,
    mem_port_arbiter_if.master    mem
);
    localparam int LOFF = line_off_of(MEM_WIDTH);
    localparam int CW   = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    state_t          state;
    owner_t          owner;
    owner_t          grant;
    logic            rw;
    logic [CW-1:0]   cnt;
    logic [LOFF-3:0] wsel;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req_i      (ic_req),
        .req_d      (d_ce),
        .update     (state == DONE),
        .done_owner (owner),
        .grant      (grant)
    );

    assign d_hold = d_ce & ~d_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            owner             <= OWN_D;
            rw                <= 1'b1;
            cnt               <= '0;
            wsel              <= '0;
            mem.ce_n          <= 1'b1;
            mem.we_n          <= 1'b1;
            mem.oe_n          <= 1'b1;
            mem.bw            <= 1'b0;
            mem.multiple_read <= 1'b0;
            mem.addr          <= '0;
            mem.wdata         <= '0;
            ic_done           <= 1'b0;
            d_done            <= 1'b0;
            ic_rdata          <= '0;
            d_rdata           <= '0;
        end else begin
            ic_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: if (ic_req || d_ce) begin
                    owner    <= grant;
                    cnt      <= '0;
                    state    <= ACCESS;
                    mem.ce_n <= 1'b0;
                    if (grant == OWN_I) begin
                        // refills always fetch the whole line, so drop the in-line offset
                        rw                <= 1'b1;
                        mem.addr          <= ic_addr & ~ADDR_WIDTH'((1 << LOFF) - 1);
                        mem.bw            <= 1'b0;
                        mem.multiple_read <= 1'b1;
                        mem.oe_n          <= 1'b0;
                        mem.we_n          <= 1'b1;
                    end else begin
                        rw                <= d_rw;
                        wsel              <= d_addr[LOFF-1:2];
                        mem.addr          <= d_addr;
                        mem.bw            <= d_bw;
                        mem.wdata         <= d_wdata;
                        mem.multiple_read <= 1'b0;
                        mem.oe_n          <= ~d_rw;
                        mem.we_n          <= d_rw;
                    end
                end
                ACCESS: if (!mem.hold) begin
                    if (cnt == CW'(HOLD_CYCLES)) begin
                        state             <= DONE;
                        mem.ce_n          <= 1'b1;
                        mem.we_n          <= 1'b1;
                        mem.oe_n          <= 1'b1;
                        mem.multiple_read <= 1'b0;
                        if (owner == OWN_I) begin
                            ic_rdata <= mem.rdata;
                            ic_done  <= 1'b1;
                        end else begin
                            d_done <= 1'b1;
                            if (rw) d_rdata <= mem.rdata[{wsel, 5'd0} +: 32];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-level model for the HOLD_CYCLES=2 instance,
// directed literal checks on both instances (HOLD_CYCLES=0 and 2).
module tb_mem_port_arbiter;
  localparam int H = 2;
  localparam logic [127:0] LINE = 128'hCAFE0003_BEEF0002_F00D0001_ABCD0000;

  logic clk = 0, reset = 1;
  int n_chk = 0, n_err = 0;
  bit chk_en = 0;

  // HOLD_CYCLES=0 instance (refill latency checks)
  logic         ic_req0 = 0;
  logic [31:0]  ic_addr0 = 0;
  logic [127:0] ic_rdata0;
  logic         ic_done0;
  logic         d_ce0 = 0, d_rw0 = 0, d_bw0 = 0;
  logic [31:0]  d_addr0 = 0, d_wdata0 = 0, d_rdata0;
  logic         d_done0, d_hold0;

  // HOLD_CYCLES=2 instance (model-checked)
  logic         ic_req = 0;
  logic [31:0]  ic_addr = 0;
  logic [127:0] ic_rdata;
  logic         ic_done;
  logic         d_ce = 0, d_rw = 0, d_bw = 0;
  logic [31:0]  d_addr = 0, d_wdata = 0, d_rdata;
  logic         d_done, d_hold;

  mem_port_arbiter_if #(.MEM_WIDTH(128), .ADDR_WIDTH(32)) mif0 ();
  mem_port_arbiter_if #(.MEM_WIDTH(128), .ADDR_WIDTH(32)) mif2 ();

  mem_port_arbiter #(.HOLD_CYCLES(0), .MEM_WIDTH(128), .ADDR_WIDTH(32)) u0 (
    .clk(clk), .reset(reset), .ic_req(ic_req0), .ic_addr(ic_addr0), .ic_rdata(ic_rdata0),
    .ic_done(ic_done0), .d_ce(d_ce0), .d_rw(d_rw0), .d_bw(d_bw0), .d_addr(d_addr0),
    .d_wdata(d_wdata0), .d_rdata(d_rdata0), .d_done(d_done0), .d_hold(d_hold0), .mem(mif0));

  mem_port_arbiter #(.HOLD_CYCLES(H), .MEM_WIDTH(128), .ADDR_WIDTH(32)) u2 (
    .clk(clk), .reset(reset), .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
    .ic_done(ic_done), .d_ce(d_ce), .d_rw(d_rw), .d_bw(d_bw), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_hold(d_hold), .mem(mif2));

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  bit           m_busy = 0, m_cool = 0, m_own_d = 0, m_last_d = 1, m_rw = 1, m_bw = 0;
  bit           m_di = 0, m_dd = 0;
  int           m_left = 0;
  logic [31:0]  m_addr = 0, m_wd = 0, m_drd = 0;
  logic [127:0] m_line = 0, m_tmp;

  initial forever begin
    @(posedge clk);
    m_di = 0; m_dd = 0;
    if (reset) begin
      m_busy = 0; m_cool = 0; m_last_d = 1; m_line = '0; m_drd = '0;
    end else if (m_busy) begin
      if (!mif2.hold) begin
        if (m_left == 0) begin
          m_busy = 0; m_cool = 1; m_last_d = m_own_d;
          if (!m_own_d) begin m_di = 1; m_line = mif2.rdata; end
          else begin
            m_dd = 1;
            if (m_rw) begin m_tmp = mif2.rdata >> (32 * int'(m_addr[3:2])); m_drd = m_tmp[31:0]; end
          end
        end else m_left--;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (ic_req || d_ce) begin
`ifdef ARB_FIXED_PRIO_EN
      m_own_d = d_ce;
`else
      m_own_d = (ic_req && d_ce) ? !m_last_d : d_ce;
`endif
      m_busy = 1; m_left = H;
      if (m_own_d) begin m_rw = d_rw; m_bw = d_bw; m_addr = d_addr; m_wd = d_wdata; end
      else begin m_rw = 1; m_bw = 0; m_addr = ic_addr & ~32'hF; end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("ic_done", ic_done, m_di);
    chk("d_done", d_done, m_dd);
    chk("d_hold", d_hold, d_ce & ~m_dd);
    chk("mem_ce_n", mif2.ce_n, !m_busy);
    chk("mem_we_n", mif2.we_n, m_busy ? m_rw : 1'b1);
    chk("mem_oe_n", mif2.oe_n, m_busy ? !m_rw : 1'b1);
    chk("mem_mread", mif2.multiple_read, m_busy && !m_own_d);
    chk("d_rdata", d_rdata, m_drd);
    chk("ic_rdata", ic_rdata, m_line);
    if (m_busy) begin
      chk("mem_addr", mif2.addr, m_addr);
      chk("mem_bw", mif2.bw, m_bw);
      if (m_own_d && !m_rw) chk("mem_wdata", mif2.wdata, m_wd);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_data(input logic rw, input logic bw, input logic [31:0] a, input logic [31:0] wd,
                         input int hf, input int hl, output int lat, output int holds,
                         output logic [31:0] rd, output logic [2:0] acc);
    bit fin;
    fin = 0; lat = -1; holds = 0; rd = '0; acc = '0;
    d_ce = 1; d_rw = rw; d_bw = bw; d_addr = a; d_wdata = wd;
    for (int k = 0; k < 40 && !fin; k++) begin
      mif2.hold = (k >= hf && k < hf + hl);
      @(negedge clk);
      if (k == 1) acc = {mif2.we_n, mif2.oe_n, mif2.bw};
      if (d_hold) holds++;
      if (d_done) begin lat = k; rd = d_rdata; end
      @(posedge clk); #1;
      if (lat >= 0) begin d_ce = 0; fin = 1; end
    end
    mif2.hold = 0; d_ce = 0;
    if (lat < 0) begin n_chk++; n_err++; $display("FAIL data_timeout: got no d_done expected a pulse"); end
  endtask

  int lat, holds, li, ld, nd;
  logic [31:0]  rd, a0;
  logic [2:0]   acc;
  logic [127:0] line0;
  logic         mr0;

  initial begin
    mif0.rdata = LINE; mif0.hold = 0;
    mif2.rdata = LINE; mif2.hold = 0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1; reset = 0;

    // reset state
    @(negedge clk);
    chk("rst_strobes", {mif2.ce_n, mif2.we_n, mif2.oe_n}, 3'b111);
    chk("rst_addr", mif2.addr, 32'h0);
    chk("rst_wdata", mif2.wdata, 32'h0);
    chk("rst_bw_mr", {mif2.bw, mif2.multiple_read}, 2'b00);
    chk("rst_rdata", {ic_rdata, d_rdata}, '0);
    @(posedge clk); #1;

    // tie right after reset: I first under round-robin, D first with fixed priority
    li = -1; ld = -1;
    ic_req = 1; ic_addr = 32'h0040_0024; d_ce = 1; d_rw = 1; d_bw = 0; d_addr = 32'h1001_0004;
    for (int k = 0; k < 40 && (li < 0 || ld < 0); k++) begin
      @(negedge clk);
      if (ic_done) li = k;
      if (d_done) ld = k;
      @(posedge clk); #1;
      if (li >= 0) ic_req = 0;
      if (ld >= 0) d_ce = 0;
    end
    ic_req = 0; d_ce = 0;
`ifdef ARB_FIXED_PRIO_EN
    chk("tie_d_first", ld, 4);
    chk("tie_i_second", li, 9);
`else
    chk("tie_i_first", li, 4);
    chk("tie_d_second", ld, 9);
`endif
    chk("tie_d_word", d_rdata, 32'hF00D0001);
    chk("tie_i_line", ic_rdata, LINE);

    // refill on the zero-wait instance
    lat = -1; nd = 0;
    ic_req0 = 1; ic_addr0 = 32'h0040_0014;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) begin a0 = mif0.addr; mr0 = mif0.multiple_read; end
      if (ic_done0) begin nd++; if (lat < 0) lat = k; line0 = ic_rdata0; end
      @(posedge clk); #1;
      if (lat >= 0) ic_req0 = 0;
    end
    chk("i0_latency", lat, 2);
    chk("i0_addr_aligned", a0, 32'h0040_0010);
    chk("i0_mread", mr0, 1'b1);
    chk("i0_line", line0, LINE);
    chk("i0_done_once", nd, 1);

    // data read, word 2 of the line
    do_data(1'b1, 1'b0, 32'h1001_0008, 32'h0, 0, 0, lat, holds, rd, acc);
    chk("rd_latency", lat, 4);
    chk("rd_hold_cycles", holds, 4);
    chk("rd_word", rd, 32'hBEEF0002);
    chk("rd_strobes", acc, 3'b100);
    @(negedge clk);
    chk("rd_done_single", d_done, 1'b0);
    @(posedge clk); #1;

    // byte write leaves read data untouched
    do_data(1'b0, 1'b1, 32'h1001_0000, 32'hDEADBEEF, 0, 0, lat, holds, rd, acc);
    chk("wr_latency", lat, 4);
    chk("wr_strobes", acc, 3'b011);
    chk("wr_rdata_kept", rd, 32'hBEEF0002);

    // memory busy for 3 cycles stretches the access by exactly 3
    do_data(1'b1, 1'b0, 32'h1001_000C, 32'h0, 1, 3, lat, holds, rd, acc);
    chk("hold_latency", lat, 7);
    chk("hold_word", rd, 32'hCAFE0003);

    // reset in the middle of an access
    d_ce = 1; d_rw = 1; d_bw = 0; d_addr = 32'h1001_0004;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("midrst_in_access", mif2.ce_n, 1'b0);
    @(posedge clk); #1;
    reset = 1; d_ce = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("midrst_strobes", {mif2.ce_n, mif2.we_n, mif2.oe_n}, 3'b111);
    chk("midrst_rdata", d_rdata, 32'h0);
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (d_done) nd++;
      @(negedge clk);
    end
    chk("midrst_no_done", nd, 0);
    @(posedge clk); #1;
    do_data(1'b1, 1'b0, 32'h1001_0004, 32'h0, 0, 0, lat, holds, rd, acc);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_word", rd, 32'hF00D0001);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
